voice_allocator: RTL

- Sits between the Avalon-MM command register and the oscillator bank manager.
- Queues note-on/note-off commands, allocates them to one of NUM_VOICES voice slots, and issues one command at a time to the bank with a valid/ready handshake.
- Tracks the per-voice active/note/age table and steals the oldest voice when all voices are busy.

---
 rtl/voice_allocator.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Purpose:
//   Sits between the command register and the oscillator bank manager.
//   Note-on/note-off commands are queued in a small FIFO, assigned to one of
//   NUM_VOICES voice slots, and sent to the bank one at a time over a
//   valid/ready handshake. A per-voice table holds the active flag and note
//   number, and an age counter when voice stealing is built in.
//
// Build option:
//   VOICE_STEAL_EN - when defined, a note-on that arrives with every voice busy
//                    (and no voice already on the same note) takes over the
//                    oldest voice and pulses o_steal. When undefined, such a
//                    note-on is discarded with an o_drop pulse, o_steal stays 0
//                    and the age counters are not built.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   i_cmd_valid    one-cycle command strobe
//   i_cmd[15:0]    [15]=1 on/0 off, [14:8]=note, [7]=reserved, [6:0]=velocity
//   o_cmd_ready    command queue has room
//   o_drop         one-cycle pulse: a command was discarded
//   o_voice_valid  command to the bank is valid
//   i_voice_ready  bank accepts the command
//   o_voice_idx    target voice slot
//   o_voice_on     1 = start/retrigger, 0 = release
//   o_voice_note   note number
//   o_voice_vel    velocity (0 on release)
//   o_steal        one-cycle pulse when a busy voice is taken over
//   o_active_mask  bit v set = voice v active
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int NUM_VOICES  = 8,
  parameter int VOICE_W     = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int AGE_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  input  logic [15:0]           i_cmd,
  output logic                  o_cmd_ready,
  output logic                  o_drop,
  output logic                  o_voice_valid,
  input  logic                  i_voice_ready,
  output logic [VOICE_W-1:0]    o_voice_idx,
  output logic                  o_voice_on,
  output logic [6:0]            o_voice_note,
  output logic [6:0]            o_voice_vel,
  output logic                  o_steal,
  output logic [NUM_VOICES-1:0] o_active_mask
);

  localparam int             PTR_W      = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------------
  // Command queue. The reserved bit is not stored: entries are {on, note, vel}.
  // ---------------------------------------------------------------------------
  logic [14:0]      fifo_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             cmd_ready_reg;
  logic [14:0]      work_cmd_reg;
  logic             push, pop;
  logic             cmd_reserved_unused;

  assign cmd_reserved_unused = i_cmd[7];

  assign push = i_cmd_valid && cmd_ready_reg;
  assign pop  = (state_reg == IDLE) && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {i_cmd[15:8], i_cmd[6:0]};
    end
  end

  // Ready is registered from the post-update occupancy, so it is 0 during
  // reset and rises on the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      cmd_ready_reg <= 1'b0;
      work_cmd_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        work_cmd_reg <= fifo_mem[rd_ptr_reg];
      end
      count_reg     <= count_next;
      cmd_ready_reg <= (count_next != FULL_COUNT);
    end
  end

  // Velocity 0 on a note-on is a release.
  logic       work_is_on;
  logic [6:0] work_note, work_vel;

  assign work_note  = work_cmd_reg[13:7];
  assign work_vel   = work_cmd_reg[6:0];
  assign work_is_on = work_cmd_reg[14] && (work_vel != 7'd0);

  // ---------------------------------------------------------------------------
  // Voice table
  // ---------------------------------------------------------------------------
  logic [NUM_VOICES-1:0] active_reg, active_next, match_vec;
  logic [6:0]            tbl_note_reg  [NUM_VOICES];
  logic [6:0]            tbl_note_next [NUM_VOICES];

  logic [VOICE_W-1:0] out_idx_reg;
  logic               out_on_reg;
  logic [6:0]         out_note_reg, out_vel_reg;
  logic               handshake;

  assign handshake = (state_reg == ISSUE) && i_voice_ready;

`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  logic [AGE_W-1:0] age_reg  [NUM_VOICES];
  logic [AGE_W-1:0] age_next [NUM_VOICES];
`else
  localparam int age_w_unused = AGE_W;
`endif

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic sel;
      assign sel               = handshake && (out_idx_reg == VOICE_W'(gi));
      assign match_vec[gi]     = active_reg[gi] && (tbl_note_reg[gi] == work_note);
      assign active_next[gi]   = sel ? out_on_reg : active_reg[gi];
      assign tbl_note_next[gi] = (sel && out_on_reg) ? out_note_reg : tbl_note_reg[gi];
`ifdef VOICE_STEAL_EN
      // The target restarts at 0; on a note-on every other active voice ages.
      assign age_next[gi] = sel ? '0 :
                            (handshake && out_on_reg && active_reg[gi] &&
                             (age_reg[gi] != AGE_MAX)) ? age_reg[gi] + 1'b1 :
                            age_reg[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_reg   <= '0;
      tbl_note_reg <= '{default: '0};
`ifdef VOICE_STEAL_EN
      age_reg      <= '{default: '0};
`endif
    end else begin
      active_reg   <= active_next;
      tbl_note_reg <= tbl_note_next;
`ifdef VOICE_STEAL_EN
      age_reg      <= age_next;
`endif
    end
  end

  // Lowest-index matching voice and lowest-index free voice: scanning downward
  // lets the lowest index overwrite earlier hits.
  logic [VOICE_W-1:0] match_idx, free_idx;
  logic               match_any, free_any;

  assign match_any = |match_vec;
  assign free_any  = ~&active_reg;

  always_comb begin
    match_idx = '0;
    free_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (match_vec[v]) begin
        match_idx = VOICE_W'(v);
      end
      if (!active_reg[v]) begin
        free_idx = VOICE_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Oldest voice; the strict compare keeps ties on the lowest index.
  logic [VOICE_W-1:0] oldest_idx;
  logic [AGE_W-1:0]   oldest_age;

  always_comb begin
    oldest_idx = '0;
    oldest_age = age_reg[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_reg[v] > oldest_age) begin
        oldest_age = age_reg[v];
        oldest_idx = VOICE_W'(v);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic               lookup_go, lookup_drop, lookup_steal;
  logic [VOICE_W-1:0] lookup_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lookup_go    = 1'b0;
    lookup_drop  = 1'b0;
    lookup_steal = 1'b0;
    lookup_idx   = '0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (work_is_on) begin
          if (match_any) begin
            lookup_go  = 1'b1;
            lookup_idx = match_idx;
          end else if (free_any) begin
            lookup_go  = 1'b1;
            lookup_idx = free_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            lookup_go    = 1'b1;
            lookup_steal = 1'b1;
            lookup_idx   = oldest_idx;
`else
            lookup_drop  = 1'b1;
`endif
          end
        end else if (match_any) begin
          // A release with no matching voice is dropped without o_drop.
          lookup_go  = 1'b1;
          lookup_idx = match_idx;
        end
        state_next = lookup_go ? ISSUE : IDLE;
      end
      ISSUE: begin
        if (i_voice_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic drop_reg, steal_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_idx_reg  <= '0;
      out_on_reg   <= 1'b0;
      out_note_reg <= '0;
      out_vel_reg  <= '0;
      drop_reg     <= 1'b0;
      steal_reg    <= 1'b0;
    end else begin
      drop_reg  <= (i_cmd_valid && !cmd_ready_reg) || lookup_drop;
      steal_reg <= lookup_steal;
      if (lookup_go) begin
        out_idx_reg  <= lookup_idx;
        out_on_reg   <= work_is_on;
        out_note_reg <= work_note;
        out_vel_reg  <= work_is_on ? work_vel : 7'd0;
      end
    end
  end

  assign o_cmd_ready   = cmd_ready_reg;
  assign o_drop        = drop_reg;
  assign o_voice_valid = (state_reg == ISSUE);
  assign o_voice_idx   = out_idx_reg;
  assign o_voice_on    = out_on_reg;
  assign o_voice_note  = out_note_reg;
  assign o_voice_vel   = out_vel_reg;
  assign o_steal       = steal_reg;
  assign o_active_mask = active_reg;

endmodule
